// File: rtl/tetris_pkg.sv
// Shared playfield defaults, clear-engine state encoding and line-clear score table.
package tetris_pkg;

    localparam int ROWS_DEF   = 20;
    localparam int COLS_DEF   = 10;
    localparam int CELL_W_DEF = 4;
    localparam int SCORE_W    = 20;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        COMPACT,
        FILL,
        DONE
    } clear_state_t;

    // Indexed by lines removed in one pass; anything above four pays the four-line award.
    localparam logic [4:0][10:0] SCORE_TABLE = {11'd1200, 11'd300, 11'd100, 11'd40, 11'd0};

endpackage

// File: rtl/row_full_detect.sv
// Flags a playfield row as full when every cell in it is non-zero.
module row_full_detect
    import tetris_pkg::*;
#(
    parameter int COLS   = COLS_DEF,
    parameter int CELL_W = CELL_W_DEF
) (
    input  logic [COLS-1:0][CELL_W-1:0] row_i,
    output logic                        full_o
);

    always_comb begin
        full_o = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            if (row_i[c] == '0) begin
                full_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/line_clear_engine.sv
// Removes full rows from a captured playfield and compacts survivors towards the bottom.
// Optional scoring is enabled by defining LINE_CLEAR_SCORE_EN.
module line_clear_engine
    import tetris_pkg::*;
#(
    parameter int ROWS   = ROWS_DEF,
    parameter int COLS   = COLS_DEF,
    parameter int CELL_W = CELL_W_DEF
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   start_i,
    input  logic [ROWS-1:0][COLS-1:0][CELL_W-1:0]  map_in_i,
`ifdef LINE_CLEAR_SCORE_EN
    input  logic                                   score_clr_i,
    output logic [SCORE_W-1:0]                     score_o,
`endif
    output logic                                   busy_o,
    output logic                                   done_o,
    output logic [ROWS-1:0][COLS-1:0][CELL_W-1:0]  map_out_o,
    output logic [$clog2(ROWS+1)-1:0]              lines_cleared_o,
    output logic [ROWS-1:0]                        clear_mask_o
);

    localparam int LW = $clog2(ROWS+1);
    localparam int IW = $clog2(ROWS);

    clear_state_t                          state_q, state_d;
    logic [ROWS-1:0][COLS-1:0][CELL_W-1:0] board_q, board_d;
    logic [ROWS-1:0]                       mask_q, mask_d;
    logic [LW-1:0]                         lines_q, lines_d;
    logic [IW-1:0]                         rd_q, rd_d;
    logic [IW-1:0]                         wr_q, wr_d;
    logic                                  rowFull;

    row_full_detect #(
        .COLS   (COLS),
        .CELL_W (CELL_W)
    ) u_row_full (
        .row_i  (board_q[rd_q]),
        .full_o (rowFull)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            board_q <= '0;
            mask_q  <= '0;
            lines_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
        end else begin
            board_q <= board_d;
            mask_q  <= mask_d;
            lines_q <= lines_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    // Compaction runs in place: wr never sits above rd, so a source row is read before it is overwritten.
    always_comb begin
        state_d = state_q;
        board_d = board_q;
        mask_d  = mask_q;
        lines_d = lines_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    board_d = map_in_i;
                    mask_d  = '0;
                    lines_d = '0;
                    rd_d    = IW'(ROWS-1);
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (rowFull) begin
                    mask_d[rd_q] = 1'b1;
                    lines_d      = lines_q + LW'(1);
                end
                if (rd_q == '0) begin
                    rd_d    = IW'(ROWS-1);
                    wr_d    = IW'(ROWS-1);
                    state_d = COMPACT;
                end else begin
                    rd_d = rd_q - IW'(1);
                end
            end
            COMPACT: begin
                if (!mask_q[rd_q]) begin
                    board_d[wr_q] = board_q[rd_q];
                    wr_d          = wr_q - IW'(1);
                end
                rd_d = rd_q - IW'(1);
                if (rd_q == '0) begin
                    state_d = (lines_q == '0) ? DONE : FILL;
                end
            end
            FILL: begin
                board_d[wr_q] = '0;
                wr_d          = wr_q - IW'(1);
                if (wr_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_o          = (state_q != IDLE);
    assign done_o          = (state_q == DONE);
    assign map_out_o       = board_q;
    assign lines_cleared_o = lines_q;
    assign clear_mask_o    = mask_q;

`ifdef LINE_CLEAR_SCORE_EN
    localparam int SW1 = SCORE_W + 1;

    logic [SCORE_W-1:0] score_q, score_d;
    logic [2:0]         awardIdx;
    logic [SW1-1:0]     scoreSum;

    always_comb begin
        awardIdx = (int'(lines_q) >= 4) ? 3'd4 : 3'(lines_q);
        scoreSum = {1'b0, score_q} + SW1'(SCORE_TABLE[awardIdx]);
        score_d  = score_q;
        if (score_clr_i) begin
            score_d = '0;
        end else if (state_q == DONE) begin
            score_d = scoreSum[SCORE_W] ? '1 : scoreSum[SCORE_W-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            score_q <= '0;
        end else begin
            score_q <= score_d;
        end
    end

    assign score_o = score_q;
`endif

endmodule

// File: tb/tb_line_clear_engine.sv
// Scoreboard bench for line_clear_engine: directed boards push expected results, a negedge monitor checks them.
module tb_line_clear_engine;
    import tetris_pkg::*;

    localparam int ROWS = 20;
    localparam int COLS = 10;
    localparam int CW   = 4;
    localparam int LW   = 5;
    localparam int R2   = 4;
    localparam int C2   = 3;
    localparam int LW2  = 3;

    typedef logic [ROWS-1:0][COLS-1:0][CW-1:0] board_t;
    typedef logic [R2-1:0][C2-1:0][CW-1:0]     board2_t;

    typedef struct {
        logic [LW-1:0]   lines;
        logic [ROWS-1:0] mask;
        board_t          map;
        int              lat;
        int              award;
    } exp_t;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    board_t          mapIn = '0;
    logic            busy, done;
    board_t          mapOut;
    logic [LW-1:0]   lines;
    logic [ROWS-1:0] mask;

    logic            start2 = 1'b0;
    board2_t         mapIn2 = '0;
    logic            busy2, done2;
    board2_t         mapOut2;
    logic [LW2-1:0]  lines2;
    logic [R2-1:0]   mask2;

`ifdef LINE_CLEAR_SCORE_EN
    logic               scoreClr = 1'b0;
    logic [SCORE_W-1:0] score, score2;
`endif

    line_clear_engine #(.ROWS(ROWS), .COLS(COLS), .CELL_W(CW)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .start_i         (start),
        .map_in_i        (mapIn),
`ifdef LINE_CLEAR_SCORE_EN
        .score_clr_i     (scoreClr),
        .score_o         (score),
`endif
        .busy_o          (busy),
        .done_o          (done),
        .map_out_o       (mapOut),
        .lines_cleared_o (lines),
        .clear_mask_o    (mask)
    );

    line_clear_engine #(.ROWS(R2), .COLS(C2), .CELL_W(CW)) dut2 (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .start_i         (start2),
        .map_in_i        (mapIn2),
`ifdef LINE_CLEAR_SCORE_EN
        .score_clr_i     (scoreClr),
        .score_o         (score2),
`endif
        .busy_o          (busy2),
        .done_o          (done2),
        .map_out_o       (mapOut2),
        .lines_cleared_o (lines2),
        .clear_mask_o    (mask2)
    );

    always #5 clk = ~clk;

    int   cnt       = 0;
    int   issueCnt  = 0;
    int   issueCnt2 = 0;
    int   checks    = 0;
    int   failures  = 0;
    int   idleReq   = 0;
    int   idleSeen  = 0;
    int   req2      = 0;
    int   seen2     = 0;
    exp_t expQ[$];
    exp_t monE;
`ifdef LINE_CLEAR_SCORE_EN
    int   expScore     = 0;
    bit   scorePending = 1'b0;
`endif

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mkExp(input int l, input logic [ROWS-1:0] m, input board_t b,
                                   input int lat, input int award);
        exp_t e;
        e.lines = LW'(l);
        e.mask  = m;
        e.map   = b;
        e.lat   = lat;
        e.award = award;
        return e;
    endfunction

    // Monitor: every negedge, serve idle-check requests and pop one expectation per done pulse.
    always @(negedge clk) begin
        cnt++;
`ifdef LINE_CLEAR_SCORE_EN
        if (!rst_n) begin
            expScore = 0;
        end
        if (scorePending) begin
            scorePending = 1'b0;
            checkOutput("score", 64'(score), 64'(expScore));
        end
`endif
        if (idleReq != idleSeen) begin
            idleSeen = idleReq;
            checkOutput("idle_busy", 64'(busy), 64'd0);
            checkOutput("idle_done", 64'(done), 64'd0);
            checkOutput("idle_lines", 64'(lines), 64'd0);
            checkOutput("idle_mask", 64'(mask), 64'd0);
            for (int r = 0; r < ROWS; r++) begin
                checkOutput($sformatf("idle_map_row%0d", r), 64'(mapOut[r]), 64'd0);
            end
        end
        if (done) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_done", 64'(done), 64'd0);
            end else begin
                monE = expQ.pop_front();
                checkOutput("latency", 64'(cnt - issueCnt), 64'(monE.lat));
                checkOutput("lines_cleared", 64'(lines), 64'(monE.lines));
                checkOutput("clear_mask", 64'(mask), 64'(monE.mask));
                for (int r = 0; r < ROWS; r++) begin
                    checkOutput($sformatf("map_row%0d", r), 64'(mapOut[r]), 64'(monE.map[r]));
                end
`ifdef LINE_CLEAR_SCORE_EN
                expScore     = expScore + monE.award;
                scorePending = 1'b1;
`endif
            end
        end else if (expQ.size() > 0 && (cnt - issueCnt) > 150) begin
            checkOutput("done_timeout", 64'(done), 64'd1);
            monE = expQ.pop_front();
        end
        if (done2) begin
            if (seen2 == req2) begin
                checkOutput("dut2_unexpected_done", 64'(done2), 64'd0);
            end else begin
                seen2 = req2;
                checkOutput("dut2_latency", 64'(cnt - issueCnt2), 64'd13);
                checkOutput("dut2_lines", 64'(lines2), 64'd4);
                checkOutput("dut2_mask", 64'(mask2), 64'hF);
                checkOutput("dut2_map", 64'(mapOut2), 64'd0);
            end
        end else if (seen2 != req2 && (cnt - issueCnt2) > 60) begin
            checkOutput("dut2_timeout", 64'(done2), 64'd1);
            seen2 = req2;
        end
    end

    task automatic applyStimulus(input board_t b, input exp_t e, input bit push);
        @(negedge clk);
        #1;
        mapIn    = b;
        start    = 1'b1;
        issueCnt = cnt;
        if (push) begin
            expQ.push_back(e);
        end
        @(negedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (expQ.size() == 0 && !busy && seen2 == req2 && !busy2) begin
                break;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic requestIdleCheck();
        idleReq++;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        board_t b, m, b3, m3;
        exp_t   e3;

        repeat (2) @(negedge clk);
        requestIdleCheck();
        #1;
        rst_n = 1'b1;

        // Empty board passes through untouched.
        b = '0;
        applyStimulus(b, mkExp(0, '0, b, 41, 0), 1'b1);
        waitIdle();

        // Single bottom clear, lone cell drops one row.
        b3 = '0;
        b3[19] = {COLS{4'h3}};
        b3[18][0] = 4'h5;
        m3 = '0;
        m3[19][0] = 4'h5;
        e3 = mkExp(1, 20'h80000, m3, 42, 40);
        applyStimulus(b3, e3, 1'b1);
        waitIdle();

        // Non-contiguous clears; map_in is disturbed after acceptance.
        b = '0;
        b[19] = {COLS{4'h1}};
        b[17] = {COLS{4'h2}};
        b[16] = {COLS{4'hF}};
        b[14] = {COLS{4'h7}};
        b[18][2] = 4'h7;
        b[18][9] = 4'hC;
        b[15][0] = 4'h1;
        b[15][5] = 4'hA;
        m = '0;
        m[19][2] = 4'h7;
        m[19][9] = 4'hC;
        m[18][0] = 4'h1;
        m[18][5] = 4'hA;
        applyStimulus(b, mkExp(4, 20'hB4000, m, 45, 1200), 1'b1);
        mapIn = '1;
        waitIdle();

        // Mid-board clear; extra start pulses during SCAN and across the DONE cycle are ignored.
        b = '0;
        b[5] = {COLS{4'h1}};
        b[3][4] = 4'h2;
        b[7][7] = 4'h9;
        m = '0;
        m[7][7] = 4'h9;
        m[4][4] = 4'h2;
        applyStimulus(b, mkExp(1, 20'h00020, m, 42, 40), 1'b1);
        repeat (4) @(negedge clk);
        #1;
        start = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 100 && cnt < issueCnt + 41; i++) begin
            @(negedge clk);
            #1;
        end
        start = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        waitIdle();

        // Reset during COMPACT discards the pass; first edge after release accepts a new start.
        applyStimulus(b3, e3, 1'b0);
        repeat (24) @(negedge clk);
        #1;
        rst_n = 1'b0;
        requestIdleCheck();
        #1;
        rst_n    = 1'b1;
        mapIn    = b3;
        start    = 1'b1;
        issueCnt = cnt;
        expQ.push_back(e3);
        @(negedge clk);
        #1;
        start = 1'b0;
        waitIdle();

        // Every row full.
        b = '0;
        for (int r = 0; r < ROWS; r++) begin
            b[r] = {COLS{4'(r % 15 + 1)}};
        end
        applyStimulus(b, mkExp(20, '1, '0, 61, 1200), 1'b1);
        waitIdle();

        // Small 4x3 instance, every row full.
        @(negedge clk);
        #1;
        mapIn2    = {(R2*C2){4'h9}};
        start2    = 1'b1;
        issueCnt2 = cnt;
        req2++;
        @(negedge clk);
        #1;
        start2 = 1'b0;
        waitIdle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
